// File: rtl/sys_defs.sv
// Shared rename-stage definitions.
//   PHYS_TAG   physical register tag
//   MAP_ENTRY  one map-table entry {phys_reg, ready}
//   CDB_ENTRY  one CDB broadcast {valid, tag}
//   MAP_TABLE  a whole architectural map (`ARCH_REG_SZ entries)
//   CKPT_ID    checkpoint slot id
// Sizing macros: `ARCH_REG_SZ, `N (CDB width), `NUM_CKPT, `PHYS_REG_SZ.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define ARCH_REG_SZ 32
`define N 2
`define NUM_CKPT 4
`define PHYS_REG_SZ 64
`endif

package sys_defs;

  localparam int PHYS_TAG_W = $clog2(`PHYS_REG_SZ);

  typedef logic [PHYS_TAG_W-1:0] PHYS_TAG;

  typedef struct packed {
    PHYS_TAG phys_reg;
    logic    ready;
  } MAP_ENTRY;

  typedef struct packed {
    logic    valid;
    PHYS_TAG tag;
  } CDB_ENTRY;

  typedef MAP_ENTRY [`ARCH_REG_SZ-1:0] MAP_TABLE;

  typedef logic [$clog2(`NUM_CKPT)-1:0] CKPT_ID;

  typedef enum logic {
    IDLE,
    RESTORE
  } ckpt_state_e;

  // True when any valid CDB lane carries tag t.
  function automatic logic tag_hit(input PHYS_TAG t, input CDB_ENTRY [`N-1:0] cdb);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < `N; k++) begin
      if (cdb[k].valid && (cdb[k].tag == t)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/map_ready_merge.sv
// Combinational wakeup merge for a whole map table.
//   map_in   map table as stored
//   cdb      this cycle's CDB broadcasts
//   map_out  map_in with ready set on every entry whose phys_reg is broadcast
module map_ready_merge
  import sys_defs::*;
(
  input  MAP_TABLE             map_in,
  input  CDB_ENTRY [`N-1:0]    cdb,
  output MAP_TABLE             map_out
);

  always_comb begin
    map_out = map_in;
    for (int r = 0; r < `ARCH_REG_SZ; r++) begin
      if (tag_hit(map_in[r].phys_reg, cdb)) map_out[r].ready = 1'b1;
    end
  end

endmodule

// File: rtl/rename_checkpoint_ctrl.sv
// Branch checkpoint manager for the rename stage.
// Keeps one copy of the speculative map per in-flight branch in a circular
// buffer (allocated in order, freed out of order), snoops the CDB into every
// stored copy, and on a mispredict drives the saved map to the map table's
// restore port for exactly one cycle.
//   clock, reset         clock; asynchronous active-low reset
//   ckpt_req/ckpt_table  branch checkpoint request and the map it sees
//   ckpt_gnt/ckpt_id     grant and assigned slot
//   ckpt_full            no free slot (registered occupancy only)
//   resolve_*            branch resolution (id, mispredict flag)
//   cdb_broadcasts       completing tags
//   table_restore(_en)   restore map and one-cycle load strobe
//   resolve_err          sticky: a resolve named a non-live slot
module rename_checkpoint_ctrl
  import sys_defs::*;
#(
  parameter int NUM_CKPT   = `NUM_CKPT,
  parameter int CKPT_IDX_W = $clog2(NUM_CKPT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ckpt_req,
  input  MAP_TABLE              ckpt_table,
  output logic                  ckpt_gnt,
  output logic [CKPT_IDX_W-1:0] ckpt_id,
  output logic                  ckpt_full,
  input  logic                  resolve_valid,
  input  logic [CKPT_IDX_W-1:0] resolve_id,
  input  logic                  resolve_mispredict,
  input  CDB_ENTRY [`N-1:0]     cdb_broadcasts,
  output MAP_TABLE              table_restore,
  output logic                  table_restore_en,
  output logic                  resolve_err
);

  localparam int PTR_W = CKPT_IDX_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;

  // Pointers carry a wrap bit above the slot index so full and empty differ.
  ptr_t                head_q, head_d;
  ptr_t                tail_q, tail_d;
  logic [NUM_CKPT-1:0] valid_q, valid_d;
  ckpt_state_e         state_q, state_d;
  logic                resolve_err_q, resolve_err_d;
  MAP_TABLE            restore_q, restore_d;
  MAP_TABLE            store_q      [NUM_CKPT];
  MAP_TABLE            store_d      [NUM_CKPT];
  MAP_TABLE            store_merged [NUM_CKPT];
  MAP_TABLE            restore_merged;
  MAP_TABLE            req_merged;

  // Wakeup merges: one per stored slot, one for the restore copy, one for the
  // incoming request so a tag completing in the grant cycle is not lost.
  for (genvar g = 0; g < NUM_CKPT; g++) begin : g_slot_merge
    map_ready_merge u_slot_merge (
      .map_in  (store_q[g]),
      .cdb     (cdb_broadcasts),
      .map_out (store_merged[g])
    );
  end

  map_ready_merge u_restore_merge (
    .map_in  (restore_q),
    .cdb     (cdb_broadcasts),
    .map_out (restore_merged)
  );

  map_ready_merge u_req_merge (
    .map_in  (ckpt_table),
    .cdb     (cdb_broadcasts),
    .map_out (req_merged)
  );

  logic [CKPT_IDX_W-1:0] head_idx, tail_idx, off_idx;
  ptr_t                  span, rid_ptr, squash_span;
  logic                  is_idle, rid_live, mp_fire, ok_fire, err_fire;

  // NOTE: every _d variable gets its hold value first, so no path through this
  // block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    head_idx  = head_q[CKPT_IDX_W-1:0];
    tail_idx  = tail_q[CKPT_IDX_W-1:0];
    span      = tail_q - head_q;
    ckpt_full = (span == ptr_t'(NUM_CKPT));
    is_idle   = (state_q == IDLE);
    rid_live  = valid_q[resolve_id];
    mp_fire   = is_idle & resolve_valid &  resolve_mispredict & rid_live;
    ok_fire   = is_idle & resolve_valid & ~resolve_mispredict & rid_live;
    err_fire  = is_idle & resolve_valid & ~rid_live;

    // A same-cycle mispredict squashes the requesting (younger) branch.
    ckpt_gnt  = is_idle & ckpt_req & ~ckpt_full & ~(resolve_valid & resolve_mispredict);
    ckpt_id   = tail_idx;

    // Full pointer of the resolving slot: a live slot lies in [head, tail), so
    // an index below head's index belongs to the next lap.
    rid_ptr     = {(resolve_id >= head_idx) ? head_q[CKPT_IDX_W] : ~head_q[CKPT_IDX_W],
                   resolve_id};
    squash_span = tail_q - rid_ptr;

    head_d        = head_q;
    tail_d        = tail_q;
    valid_d       = valid_q;
    state_d       = IDLE;
    resolve_err_d = resolve_err_q | err_fire;
    restore_d     = restore_merged;
    off_idx       = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      store_d[i] = valid_q[i] ? store_merged[i] : store_q[i];
    end

    // Retire freed slots at the head, one per cycle.
    if ((span != '0) && !valid_q[head_idx]) head_d = head_q + ptr_t'(1);

    if (ckpt_gnt) begin
      store_d[tail_idx] = req_merged;
      valid_d[tail_idx] = 1'b1;
      tail_d            = tail_q + ptr_t'(1);
    end

    if (ok_fire) valid_d[resolve_id] = 1'b0;

    if (mp_fire) begin
      restore_d = store_merged[resolve_id];
      // Squash the resolving slot and every younger slot up to tail.
      for (int i = 0; i < NUM_CKPT; i++) begin
        off_idx = CKPT_IDX_W'(i) - resolve_id;
        if (ptr_t'({1'b0, off_idx}) < squash_span) valid_d[i] = 1'b0;
      end
      tail_d  = rid_ptr;
      state_d = RESTORE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge _d values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      valid_q       <= '0;
      state_q       <= IDLE;
      resolve_err_q <= 1'b0;
      restore_q     <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      valid_q       <= valid_d;
      state_q       <= state_d;
      resolve_err_q <= resolve_err_d;
      restore_q     <= restore_d;
    end
  end

  // NOTE: the checkpoint payload is not reset; valid_q gates every use of it,
  // so clearing it would only add reset fanout to a wide array.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CKPT; i++) begin
      store_q[i] <= store_d[i];
    end
  end

  // The restore strobe comes straight from state_q so an asserted reset drops
  // it without waiting for a clock.
  assign table_restore_en = (state_q == RESTORE);
  assign table_restore    = table_restore_en ? restore_merged : restore_q;
  assign resolve_err      = resolve_err_q;

endmodule

// File: tb/tb_rename_checkpoint_ctrl.sv
// Directed self-checking bench for rename_checkpoint_ctrl. Expected grant ids
// and restore maps are queued when stimulus is driven and popped when the DUT
// presents a grant or a restore strobe.
module tb_rename_checkpoint_ctrl;
  import sys_defs::*;

  localparam int NC = `NUM_CKPT;
  localparam int IW = $clog2(NC);

  logic                clock;
  logic                reset;
  logic                ckpt_req;
  MAP_TABLE            ckpt_table;
  logic                ckpt_gnt;
  logic [IW-1:0]       ckpt_id;
  logic                ckpt_full;
  logic                resolve_valid;
  logic [IW-1:0]       resolve_id;
  logic                resolve_mispredict;
  CDB_ENTRY [`N-1:0]   cdb_broadcasts;
  MAP_TABLE            table_restore;
  logic                table_restore_en;
  logic                resolve_err;

  int       checks = 0;
  int       errors = 0;
  int       exp_gnt_q[$];
  MAP_TABLE exp_rst_q[$];

  rename_checkpoint_ctrl #(.NUM_CKPT(NC)) dut (
    .clock              (clock),
    .reset              (reset),
    .ckpt_req           (ckpt_req),
    .ckpt_table         (ckpt_table),
    .ckpt_gnt           (ckpt_gnt),
    .ckpt_id            (ckpt_id),
    .ckpt_full          (ckpt_full),
    .resolve_valid      (resolve_valid),
    .resolve_id         (resolve_id),
    .resolve_mispredict (resolve_mispredict),
    .cdb_broadcasts     (cdb_broadcasts),
    .table_restore      (table_restore),
    .table_restore_en   (table_restore_en),
    .resolve_err        (resolve_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ckpt_req           = 1'b0;
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
    resolve_id         = '0;
    cdb_broadcasts     = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_cdb(input int tag);
    cdb_broadcasts          = '0;
    cdb_broadcasts[0].valid = 1'b1;
    cdb_broadcasts[0].tag   = PHYS_TAG'(tag);
  endtask

  function automatic MAP_TABLE base_map();
    MAP_TABLE m;
    for (int r = 0; r < `ARCH_REG_SZ; r++) begin
      m[r].phys_reg = PHYS_TAG'(r);
      m[r].ready    = 1'b1;
    end
    return m;
  endfunction

  // Pop the expected id whenever the DUT grants.
  task automatic observe_gnt(input string tag);
    if (ckpt_gnt === 1'b1) begin
      if (exp_gnt_q.size() == 0) check({tag, "_unexpected_gnt"}, ckpt_gnt, 0);
      else                       check({tag, "_id"}, ckpt_id, exp_gnt_q.pop_front());
    end
  endtask

  // Drive one request expecting a grant with exp_id, then clock it in.
  task automatic alloc(input string tag, input MAP_TABLE t, input int exp_id);
    ckpt_table = t;
    ckpt_req   = 1'b1;
    exp_gnt_q.push_back(exp_id);
    #1;
    check({tag, "_gnt"}, ckpt_gnt, 1);
    observe_gnt(tag);
    tick();
    ckpt_req = 1'b0;
  endtask

  // Called in the cycle after a mispredict: strobe must be up, map must match.
  task automatic observe_restore(input string tag);
    check({tag, "_en"}, table_restore_en, 1);
    if (table_restore_en === 1'b1 && exp_rst_q.size() != 0)
      check({tag, "_map"}, table_restore, exp_rst_q.pop_front());
  endtask

  task automatic mispredict(input int id);
    resolve_valid      = 1'b1;
    resolve_mispredict = 1'b1;
    resolve_id         = IW'(id);
  endtask

  task automatic correct(input int id);
    resolve_valid      = 1'b1;
    resolve_mispredict = 1'b0;
    resolve_id         = IW'(id);
  endtask

  MAP_TABLE t;
  MAP_TABLE e;

  initial begin
    reset      = 1'b0;
    ckpt_table = base_map();
    idle();

    // Reset state
    tick();
    check("rst_gnt", ckpt_gnt, 0);
    check("rst_full", ckpt_full, 0);
    check("rst_en", table_restore_en, 0);
    check("rst_map", table_restore, 0);
    check("rst_err", resolve_err, 0);
    check("rst_valid", dut.valid_q, 0);
    reset = 1'b1;

    // 1. Fill: ids 0..3, then fifth request denied while full
    for (int i = 0; i < NC; i++) alloc($sformatf("t1_a%0d", i), base_map(), i);
    ckpt_req = 1'b1;
    #1;
    check("t1_full", ckpt_full, 1);
    check("t1_deny_gnt", ckpt_gnt, 0);
    ckpt_req = 1'b0;

    // 2. Out-of-order free: id2 then id0 correct
    correct(2);
    tick();
    correct(0);
    tick();
    idle();
    check("t2_full_hold", ckpt_full, 1);
    tick();
    check("t2_head_1", dut.head_q, 1);
    check("t2_full_drop", ckpt_full, 0);
    tick();
    check("t2_head_stay", dut.head_q, 1);
    alloc("t2_reuse", base_map(), 0);

    // 3. Mispredict squash of id1 (x5 -> p40)
    do_reset();
    alloc("t3_a0", base_map(), 0);
    t = base_map();
    t[5].phys_reg = PHYS_TAG'(40);
    alloc("t3_a1", t, 1);
    alloc("t3_a2", base_map(), 2);
    mispredict(1);
    exp_rst_q.push_back(t);
    tick();
    idle();
    observe_restore("t3");
    check("t3_x5_p40", table_restore[5].phys_reg, 40);
    check("t3_valid", dut.valid_q, 4'b0001);
    tick();
    check("t3_en_low", table_restore_en, 0);
    alloc("t3_next", base_map(), 1);

    // 4a. CDB snoop into a stored checkpoint
    do_reset();
    t = base_map();
    t[7].phys_reg = PHYS_TAG'(33);
    t[7].ready    = 1'b0;
    alloc("t4_a0", t, 0);
    tick();
    set_cdb(33);
    tick();
    idle();
    e = t;
    e[7].ready = 1'b1;
    mispredict(0);
    exp_rst_q.push_back(e);
    tick();
    idle();
    observe_restore("t4_snoop");
    check("t4_x7_ready", table_restore[7].ready, 1);
    tick();

    // 4b. Tag broadcast during the RESTORE cycle itself
    alloc("t4_b0", t, 0);
    mispredict(0);
    tick();
    idle();
    set_cdb(33);
    exp_rst_q.push_back(e);
    #1;
    observe_restore("t4_late");
    check("t4_late_x7_ready", table_restore[7].ready, 1);
    idle();
    tick();

    // 5. Collision: request and mispredict together; grant-cycle CDB merge
    do_reset();
    alloc("t5_a0", base_map(), 0);
    t = base_map();
    t[3].phys_reg = PHYS_TAG'(50);
    t[3].ready    = 1'b0;
    set_cdb(50);
    alloc("t5_a1", t, 1);
    idle();
    e = t;
    e[3].ready = 1'b1;
    ckpt_req   = 1'b1;
    ckpt_table = base_map();
    mispredict(1);
    exp_rst_q.push_back(e);
    #1;
    check("t5_collide_gnt", ckpt_gnt, 0);
    tick();
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
    #1;
    observe_restore("t5");
    check("t5_restore_gnt", ckpt_gnt, 0);
    check("t5_tail", dut.tail_q, 1);
    tick();
    exp_gnt_q.push_back(1);
    #1;
    check("t5_single_strobe", table_restore_en, 0);
    check("t5_regrant", ckpt_gnt, 1);
    observe_gnt("t5_regrant");
    tick();
    idle();

    // 6. Resolve of an unallocated id, then reset during RESTORE
    do_reset();
    alloc("t6_a0", base_map(), 0);
    alloc("t6_a1", base_map(), 1);
    correct(3);
    tick();
    idle();
    check("t6_err", resolve_err, 1);
    check("t6_head", dut.head_q, 0);
    check("t6_tail", dut.tail_q, 2);
    check("t6_valid_kept", dut.valid_q, 4'b0011);
    mispredict(1);
    exp_rst_q.push_back(base_map());
    tick();
    idle();
    observe_restore("t6");
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_en", table_restore_en, 0);
    check("t6_async_valid", dut.valid_q, 0);
    check("t6_async_err", resolve_err, 0);
    check("t6_async_map", table_restore, 0);
    reset = 1'b1;
    tick();

    check("gnt_queue_drained", exp_gnt_q.size(), 0);
    check("restore_queue_drained", exp_rst_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_checkpoint_ctrl.md
Name: rename_checkpoint_ctrl

Overview:
Branch checkpoint manager for the rename stage. It captures a copy of the speculative register map for each dispatched branch and keeps the ready bits in every stored copy current by snooping the CDB. On a mispredict it drives the stored copy into the map table's restore port for one cycle. Checkpoints are kept in dispatch order in a circular buffer, allocated in order and freed out of order.

Parameters:
NUM_CKPT, 4, number of checkpoint slots; power of two, at least 2
CKPT_IDX_W, $clog2(NUM_CKPT), width of a checkpoint id

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-low; state clears immediately while reset==0
ckpt_req  in  1  a dispatching branch requests a checkpoint this cycle
ckpt_table  in  MAP_ENTRY[`ARCH_REG_SZ]  map view the branch sees (includes older same-bundle renames)
ckpt_gnt  out  1  checkpoint accepted this cycle
ckpt_id  out  CKPT_IDX_W  slot id assigned; valid when ckpt_gnt==1
ckpt_full  out  1  no slot free; dispatch must stall branches
resolve_valid  in  1  a branch resolves this cycle
resolve_id  in  CKPT_IDX_W  checkpoint id of the resolving branch
resolve_mispredict  in  1  1 = mispredicted, 0 = correct
cdb_broadcasts  in  CDB_ENTRY[`N]  completing tags
table_restore  out  MAP_ENTRY[`ARCH_REG_SZ]  map to load into the map table
table_restore_en  out  1  one-cycle restore strobe to the map table
resolve_err  out  1  sticky; set when a resolve names a slot that is not valid

Behaviour:
- State:
  - head_q, tail_q: CKPT_IDX_W+1 bits each; the MSB is the wrap bit.
  - valid_q[NUM_CKPT] and store_q[NUM_CKPT] (MAP_ENTRY arrays).
  - FSM state_q in {IDLE, RESTORE}.
  - restore_q: MAP_ENTRY array holding the table being restored.
- Reset (reset==0, async):
  - head=tail=0, all valid=0, state=IDLE, resolve_err=0, table_restore_en=0.
  - table_restore drives all zeros; ckpt_gnt=0; ckpt_full=0.
- Occupancy: span = tail_q - head_q, modulo 2^(CKPT_IDX_W+1). ckpt_full = (span == NUM_CKPT). Uses registered state only; a same-cycle free does not bypass into full.
- Allocate (IDLE only): ckpt_gnt = ckpt_req & ~ckpt_full & ~(resolve_valid & resolve_mispredict).
  - ckpt_id = tail_q[CKPT_IDX_W-1:0].
  - On grant, store_q[slot] <= ckpt_table with each ready bit ORed with a current-cycle CDB tag match.
  - On grant, valid[slot] <= 1 and tail++.
- CDB snoop: every cycle, for every valid slot and every arch entry, set ready <= 1 if the entry's phys_reg matches any valid CDB tag. The same merge applies to restore_q.
- Correct resolve: valid[resolve_id] <= 0.
- Head retire: head advances by one per cycle while span != 0 and valid[head] == 0. It never passes tail.
- Mispredict resolve (IDLE, resolve_valid & resolve_mispredict):
  - restore_q <= store_q[resolve_id], CDB-merged.
  - Clear valid for resolve_id and for every younger slot up to tail.
  - tail_q <= the pointer for resolve_id, keeping the wrap bit consistent with head.
  - state <= RESTORE.
  - The same-cycle ckpt_req is dropped, because that branch is younger and squashed.
- RESTORE (exactly one cycle):
  - table_restore_en = 1.
  - table_restore = restore_q with ready ORed by the current-cycle CDB, so no wakeup is lost at the load edge.
  - ckpt_gnt = 0.
  - Resolves are ignored; the upstream squash guarantees none arrive.
  - Next state is IDLE.
- Latency: mispredict resolve in cycle t produces table_restore_en in cycle t+1. Allocation uses a one-slot fill per cycle (single branch per bundle).
- Outside RESTORE: table_restore_en = 0 and table_restore = restore_q.
- Error: a resolve in IDLE whose id has valid==0 sets resolve_err and causes no state change.
- Reset mid-RESTORE aborts immediately; table_restore_en goes low asynchronously.

Decomposition:
- Shared package (sys_defs): MAP_ENTRY, CDB_ENTRY, PHYS_TAG, `ARCH_REG_SZ, `N. Add CKPT_ID typedef and `NUM_CKPT to sys_defs.
- One sub-module, map_ready_merge: combinational; takes a MAP_ENTRY table and CDB_ENTRY[`N] and returns the table with ready bits set for matching tags. Instantiated per slot, for restore_q, and for ckpt_table.

Test Plan:
1. Fill: reset, then 4 consecutive ckpt_req -> ids 0,1,2,3 granted; the 5th request sees ckpt_gnt=0 and ckpt_full=1.
2. Out-of-order free: with ids 0-3 live, resolve id2 correct, then id0 correct -> head moves 0→1, stays at 1 while valid[1]=1, ckpt_full=0 next cycle; the next grant gets id 0.
3. Mispredict squash:
   - Stimulus: ids 0-2 live, x5 mapped to p40 in ckpt 1, resolve id1 mispredict.
   - Required: cycle t+1 table_restore_en=1 with entry[5].phys_reg=40; valid[1]=valid[2]=0; the next grant returns id 1.
4. CDB snoop: ckpt 0 stores x7→p33 not ready; CDB tag 33 two cycles later; mispredict id0 -> restored entry[7].ready=1. Repeat with tag 33 broadcast during the RESTORE cycle itself -> ready=1.
5. Collision: ckpt_req and mispredict in the same cycle -> ckpt_gnt=0, tail rolls back, one restore strobe only.
6. Reset/error:
   - Resolve of an unallocated id3 -> resolve_err=1, pointers unchanged.
   - Assert reset=0 during RESTORE -> table_restore_en drops without a clock, all valid=0.
